i2c_poll_sequencer: RTL and testbench
=====================================

Name: i2c_poll_sequencer

Overview:
- Autonomous I2C read-polling sequencer. It drives the handshake of the existing i2c_master core (enable/busy/miso_data) instead of holding enable high continuously.
- Each sweep reads NUM_REGS registers from one device at addresses BASE_ADDR + k*ADDR_STRIDE, then waits PERIOD_CYCLES before the next sweep.
- Results land in a parallel register bank with per-slot valid bits, so VGA/display logic can consume multiple sensor words.
- Adds transaction timeout and a sticky error flag. The single-word wrapper has neither.

Parameters:
NUM_REGS, 4, registers read per sweep (1..16)
DATA_WIDTH, 16, width of each read word
REG_ADDR_WIDTH, 16, register address width
DEV_ADDR_WIDTH, 15, device address width
BASE_ADDR, 0, register address of slot 0
ADDR_STRIDE, 1, address increment per slot
PERIOD_CYCLES, 50000, idle clk cycles between sweeps (0 = back-to-back)
TIMEOUT_CYCLES, 100000, maximum cycles per transaction before abort (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 = keep sweeping
clear_err  input  1  one-cycle pulse; clears timeout_err
device_addr  input  DEV_ADDR_WIDTH  target device; sampled at sweep start
m_enable  output  1  request to i2c_master
m_read_write  output  1  constant 1 (read)
m_register_address  output  REG_ADDR_WIDTH  current slot address
m_device_address  output  DEV_ADDR_WIDTH  latched device address
m_busy  input  1  i2c_master busy
m_miso_data  input  DATA_WIDTH  i2c_master read data
data_out  output  NUM_REGS*DATA_WIDTH  slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
valid_mask  output  NUM_REGS  bit k = slot k holds data from its most recent attempt
sample_strobe  output  1  one-cycle pulse when a slot is written
sweep_done  output  1  one-cycle pulse at end of each sweep
timeout_err  output  1  sticky; set on any timeout

Behaviour:
- Reset: all outputs 0 except m_read_write=1. State IDLE, index 0, counters 0. Asynchronous: an m_enable in flight drops immediately.
- States: IDLE, ISSUE, WAIT, NEXT, PERIOD.
- IDLE:
  - run=1 → latch device_addr into m_device_address, index=0, go ISSUE.
  - Otherwise hold.
- ISSUE:
  - m_enable=1; m_register_address = (BASE_ADDR + index*ADDR_STRIDE) truncated to REG_ADDR_WIDTH.
  - m_busy sampled 1 → m_enable=0 on the next edge, go WAIT.
- WAIT:
  - m_busy sampled 0 → on that edge: write m_miso_data to slot[index], set valid_mask[index], sample_strobe=1 for the following cycle, go NEXT.
- Timeout:
  - tcnt resets on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - tcnt reaching TIMEOUT_CYCLES-1 → m_enable=0, timeout_err=1, valid_mask[index]=0, slot data unchanged, go NEXT.
  - Timeout has priority over a same-cycle busy event.
- NEXT (one cycle):
  - index < NUM_REGS-1 and run=1 → index+1, go ISSUE.
  - index = NUM_REGS-1 → sweep_done pulse, index=0, go PERIOD.
  - run=0 at a non-final index → go IDLE, no sweep_done.
- PERIOD:
  - Count PERIOD_CYCLES cycles.
  - At the end: run=1 → re-latch device_addr, go ISSUE. run=0 → go IDLE.
  - PERIOD_CYCLES=0 → leave PERIOD after one cycle.
- run deassert mid-transaction: the current transaction completes or times out. It never aborts while busy.
- clear_err same cycle as a new timeout: set wins.
- valid_mask and data_out persist across IDLE. Only reset clears them.
- Latency: slot update lands 1 cycle after m_busy is sampled low. Idle-to-first m_enable is 1 cycle after run is sampled high.

Test Plan:
Bench config for all scenarios: NUM_REGS=4, BASE_ADDR=0x10, ADDR_STRIDE=2, PERIOD_CYCLES=10, TIMEOUT_CYCLES=20. The master model raises busy 2 cycles after enable, holds it 5 cycles, and returns 0xA000+addr.
1. Reset, then run=1, device_addr=0x1 → addresses 0x10,0x12,0x14,0x16 issued in order; data_out = {0xA016,0xA014,0xA012,0xA010}; 4 sample_strobe pulses; 1 sweep_done; valid_mask=4'hF.
2. Continue run=1 → next sweep's first m_enable rises exactly 10 cycles after the PERIOD entry cycle. Change device_addr to 0x2 mid-sweep → applied only from the next sweep.
3. Model ignores address 0x14 (busy never rises) → m_enable drops after 20 cycles; timeout_err=1; valid_mask=4'hB; slot 2 keeps its old value; 0x16 is still read. clear_err pulse → timeout_err=0.
4. Drop run while waiting on 0x12 → 0x12 completes and is stored; no m_enable for 0x14; state IDLE; no sweep_done.
5. Assert reset during WAIT → m_enable, valid_mask, data_out, and strobes are 0 within the same cycle. Release with run=1 → sweep restarts at 0x10.
6. PERIOD_CYCLES=0, busy and timeout coinciding on the same cycle → timeout wins; back-to-back sweeps have 1-cycle PERIOD gaps.

Source files
------------

// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer: autonomous read-polling front end for the i2c_master core.
// Sweeps NUM_REGS register addresses per period and banks the words with per-slot valid bits.

module i2c_poll_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  invalidate,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid
);
    // A timed-out read keeps the previous word but marks it stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (invalidate) begin
            valid <= 1'b0;
        end
    end
endmodule

module i2c_poll_sequencer #(
    parameter int NUM_REGS       = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 16,
    parameter int DEV_ADDR_WIDTH = 15,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_STRIDE    = 1,
    parameter int PERIOD_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           clear_err,
    input  logic [DEV_ADDR_WIDTH-1:0]      device_addr,
    output logic                           m_enable,
    output logic                           m_read_write,
    output logic [REG_ADDR_WIDTH-1:0]      m_register_address,
    output logic [DEV_ADDR_WIDTH-1:0]      m_device_address,
    input  logic                           m_busy,
    input  logic [DATA_WIDTH-1:0]          m_miso_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_REGS-1:0]            valid_mask,
    output logic                           sample_strobe,
    output logic                           sweep_done,
    output logic                           timeout_err
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
    // PERIOD_CYCLES of 0 or 1 both mean a single cycle spent in PERIOD.
    localparam int PLAST  = (PERIOD_CYCLES > 1) ? PERIOD_CYCLES - 1 : 0;
    localparam int PCNT_W = (PLAST > 0) ? $clog2(PLAST + 1) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PLAST);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, PERIOD} state_t;

    state_t                              state;
    logic [IDX_W-1:0]                    idx;
    logic [TCNT_W-1:0]                   tcnt;
    logic [PCNT_W-1:0]                   pcnt;
    logic                                timeout_hit;
    logic                                capture_hit;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] slot_data;

    function automatic logic [REG_ADDR_WIDTH-1:0] slot_addr(input logic [IDX_W-1:0] i);
        return REG_ADDR_WIDTH'(64'(BASE_ADDR) + 64'(i) * 64'(ADDR_STRIDE));
    endfunction

    // Timeout outranks a busy event landing on the same edge.
    assign timeout_hit  = (state == ISSUE || state == WAIT) && (tcnt == TCNT_LAST);
    assign capture_hit  = (state == WAIT) && !m_busy && !timeout_hit;
    assign m_read_write = 1'b1;
    assign data_out     = slot_data;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
        i2c_poll_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .capture   (capture_hit && (idx == IDX_W'(k))),
            .invalidate(timeout_hit && (idx == IDX_W'(k))),
            .din       (m_miso_data),
            .dout      (slot_data[k]),
            .valid     (valid_mask[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            idx                <= '0;
            tcnt               <= '0;
            pcnt               <= '0;
            m_enable           <= 1'b0;
            m_register_address <= '0;
            m_device_address   <= '0;
            sample_strobe      <= 1'b0;
            sweep_done         <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            sweep_done    <= 1'b0;
            if (clear_err) timeout_err <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    m_device_address   <= device_addr;
                    idx                <= '0;
                    m_register_address <= slot_addr('0);
                    m_enable           <= 1'b1;
                    tcnt               <= '0;
                    state              <= ISSUE;
                end
                ISSUE, WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (timeout_hit) begin
                        m_enable    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else if (state == ISSUE) begin
                        if (m_busy) begin
                            m_enable <= 1'b0;
                            state    <= WAIT;
                        end
                    end else if (!m_busy) begin
                        sample_strobe <= 1'b1;
                        state         <= NEXT;
                    end
                end
                NEXT: if (idx == IDX_LAST) begin
                    sweep_done <= 1'b1;
                    idx        <= '0;
                    pcnt       <= '0;
                    state      <= PERIOD;
                end else if (run) begin
                    idx                <= idx + 1'b1;
                    m_register_address <= slot_addr(idx + 1'b1);
                    m_enable           <= 1'b1;
                    tcnt               <= '0;
                    state              <= ISSUE;
                end else begin
                    state <= IDLE;
                end
                PERIOD: if (pcnt == PCNT_LAST) begin
                    if (run) begin
                        m_device_address   <= device_addr;
                        m_register_address <= slot_addr('0);
                        m_enable           <= 1'b1;
                        tcnt               <= '0;
                        state              <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: two instances (10-cycle and zero period) sharing one
// behavioural i2c_master model, checked against a per-slot reference bank.
`timescale 1ns/1ps
module tb_i2c_poll_sequencer;
    localparam int N = 4, DW = 16, AW = 16, DVW = 15, TMO = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run_a = 1'b0, run_b = 1'b0, clear_err = 1'b0, sel = 1'b0;
    logic busy = 1'b0;
    logic [DW-1:0] miso = '0;
    logic [DVW-1:0] device_addr = '0;
    logic en_a, rw_a, ss_a, sd_a, te_a, en_b, rw_b, ss_b, sd_b, te_b;
    logic [AW-1:0] ra_a, ra_b;
    logic [DVW-1:0] da_a, da_b;
    logic [N*DW-1:0] data_a, data_b;
    logic [N-1:0] vm_a, vm_b;

    always #5 clk = ~clk;

    i2c_poll_sequencer #(.NUM_REGS(N), .BASE_ADDR(16'h10), .ADDR_STRIDE(2),
                         .PERIOD_CYCLES(10), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .reset(reset), .run(run_a), .clear_err(clear_err), .device_addr(device_addr),
        .m_enable(en_a), .m_read_write(rw_a), .m_register_address(ra_a), .m_device_address(da_a),
        .m_busy(busy), .m_miso_data(miso), .data_out(data_a), .valid_mask(vm_a),
        .sample_strobe(ss_a), .sweep_done(sd_a), .timeout_err(te_a));

    i2c_poll_sequencer #(.NUM_REGS(N), .BASE_ADDR(16'h10), .ADDR_STRIDE(2),
                         .PERIOD_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .clear_err(clear_err), .device_addr(device_addr),
        .m_enable(en_b), .m_read_write(rw_b), .m_register_address(ra_b), .m_device_address(da_b),
        .m_busy(busy), .m_miso_data(miso), .data_out(data_b), .valid_mask(vm_b),
        .sample_strobe(ss_b), .sweep_done(sd_b), .timeout_err(te_b));

    wire           en_s = sel ? en_b : en_a;
    wire           ss_s = sel ? ss_b : ss_a;
    wire           sd_s = sel ? sd_b : sd_a;
    wire [AW-1:0]  ra_s = sel ? ra_b : ra_a;
    wire [DVW-1:0] da_s = sel ? da_b : da_a;

    // Master model: busy 2 cycles after enable, held hold_cycles, returns 0xA000+addr.
    logic [AW-1:0] ignore_addr = 16'hFFFF;
    int            hold_cycles = 5;
    logic [AW-1:0] cur;
    always begin
        @(posedge clk);
        if (!reset && en_s && ra_s != ignore_addr) begin
            cur = ra_s;
            @(posedge clk);
            busy <= 1'b1;
            miso <= 16'hA000 + cur;
            repeat (hold_cycles) @(posedge clk);
            busy <= 1'b0;
        end
    end

    // Passive monitor of the selected instance.
    int cyc = 0, n_done = 0, n_strobe = 0, t_done = 0, en_start = 0, last_gap = -1;
    logic prev_en = 1'b0;
    logic [AW-1:0]  iss_addr [$];
    logic [DVW-1:0] iss_dev  [$];
    int             lens     [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            if (sd_s) begin n_done++; t_done = cyc; end
            if (ss_s) n_strobe++;
            if (en_s && !prev_en) begin
                iss_addr.push_back(ra_s);
                iss_dev.push_back(da_s);
                en_start = cyc;
                last_gap = cyc - t_done;
            end
            if (!en_s && prev_en) lens.push_back(cyc - en_start);
            prev_en = en_s;
        end
    end

    // Reference bank, updated per sweep from the slot rules.
    logic [DW-1:0] ex_data [2][N];
    logic [N-1:0]  ex_vld  [2];
    logic          ex_err  [2];
    int n_vec = 0, n_err = 0;

    function automatic logic [AW-1:0] slot_addr(input int k);
        return AW'(16'h10 + 2 * k);
    endfunction

    function automatic logic [N*DW-1:0] exp_bank(input int inst);
        logic [N*DW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = ex_data[inst][k];
        return v;
    endfunction

    task automatic predict_sweep(input int inst, input logic [AW-1:0] ign, input int hold);
        for (int k = 0; k < N; k++) begin
            if (slot_addr(k) == ign || hold + 3 >= TMO) begin
                ex_vld[inst][k] = 1'b0;
                ex_err[inst] = 1'b1;
            end else begin
                ex_data[inst][k] = 16'hA000 + slot_addr(k);
                ex_vld[inst][k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (n_done < target && n < 1000) begin tick(); n++; end
        chk({tag, "_done_seen"}, 64'(n_done >= target), 64'(1));
    endtask

    task automatic wait_issue(input int target, input string tag);
        int n = 0;
        while (iss_addr.size() < target && n < 1000) begin tick(); n++; end
        chk({tag, "_issue_seen"}, 64'(iss_addr.size() >= target), 64'(1));
    endtask

    task automatic check_sweep(input string tag, input int base, input logic [DVW-1:0] dev);
        chk({tag, "_count"}, 64'(iss_addr.size() - base), 64'(N));
        for (int k = 0; k < N; k++) begin
            chk({tag, "_addr"}, 64'(iss_addr[base+k]), 64'(slot_addr(k)));
            chk({tag, "_dev"}, 64'(iss_dev[base+k]), 64'(dev));
        end
    endtask

    task automatic check_bank(input string tag, input int inst);
        chk({tag, "_data"}, inst ? data_b : data_a, exp_bank(inst));
        chk({tag, "_valid"}, 64'(inst ? vm_b : vm_a), 64'(ex_vld[inst]));
        chk({tag, "_err"}, 64'(inst ? te_b : te_a), 64'(ex_err[inst]));
    endtask

    initial begin
        int base, d0, s0, ign_k;
        logic [DVW-1:0] dev;
        logic [AW-1:0] ign;
        for (int i = 0; i < 2; i++) begin
            ex_vld[i] = '0;
            ex_err[i] = 1'b0;
            for (int k = 0; k < N; k++) ex_data[i][k] = '0;
        end
        #2 reset = 1'b1;
        repeat (3) tick();
        chk("rst_en", 64'(en_a), 64'(0));
        chk("rst_rw", 64'(rw_a), 64'(1));
        chk("rst_rw_b", 64'(rw_b), 64'(1));
        chk("rst_ra", 64'(ra_a), 64'(0));
        chk("rst_da", 64'(da_a), 64'(0));
        chk("rst_ss", 64'(ss_a), 64'(0));
        chk("rst_sd", 64'(sd_a), 64'(0));
        check_bank("rst", 0);
        check_bank("rst_b", 1);
        reset = 1'b0;
        tick();

        // First sweep from IDLE, device 0x1
        device_addr = 15'h1;
        base = iss_addr.size(); d0 = n_done; s0 = n_strobe;
        run_a = 1'b1;
        tick();
        chk("first_en_latency", 64'(en_a), 64'(1));
        chk("first_reg_addr", 64'(ra_a), 64'(16'h10));
        chk("first_dev_addr", 64'(da_a), 64'(15'h1));
        wait_done(d0 + 1, "s1");
        predict_sweep(0, 16'hFFFF, 5);
        check_sweep("s1", base, 15'h1);
        chk("s1_strobes", 64'(n_strobe - s0), 64'(N));
        chk("s1_done_pulses", 64'(n_done - d0), 64'(1));
        check_bank("s1", 0);

        // Period gap and mid-sweep device change
        base = iss_addr.size(); d0 = n_done;
        wait_issue(base + 1, "s2");
        chk("s2_period_gap", 64'(last_gap), 64'(10));
        wait_issue(base + 2, "s2b");
        device_addr = 15'h2;
        wait_done(d0 + 1, "s2");
        predict_sweep(0, 16'hFFFF, 5);
        check_sweep("s2", base, 15'h1);
        check_bank("s2", 0);

        // Slot 2 address ignored -> timeout
        base = iss_addr.size(); d0 = n_done;
        ignore_addr = 16'h14;
        wait_done(d0 + 1, "s3");
        ignore_addr = 16'hFFFF;
        predict_sweep(0, 16'h14, 5);
        check_sweep("s3", base, 15'h2);
        chk("s3_timeout_len", 64'(lens[base+2]), 64'(TMO));
        check_bank("s3", 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        ex_err[0] = 1'b0;
        chk("s3_clear_err", 64'(te_a), 64'(0));

        // Randomized sweeps: random device and random ignored slot
        for (int r = 0; r < 4; r++) begin
            base = iss_addr.size(); d0 = n_done;
            dev = DVW'($urandom_range(1, 32767));
            ign_k = $urandom_range(0, 4);
            ign = (ign_k == 4) ? 16'hFFFF : slot_addr(ign_k);
            device_addr = dev;
            ignore_addr = ign;
            wait_done(d0 + 1, "rnd");
            predict_sweep(0, ign, 5);
            check_sweep("rnd", base, dev);
            check_bank("rnd", 0);
        end
        ignore_addr = 16'hFFFF;

        // Async reset with enable in flight, then run drop while on 0x12
        base = iss_addr.size();
        wait_issue(base + 2, "pre_rst");
        reset = 1'b1;
        #1;
        chk("arst_en", 64'(en_a), 64'(0));
        chk("arst_ss", 64'(ss_a), 64'(0));
        chk("arst_sd", 64'(sd_a), 64'(0));
        for (int k = 0; k < N; k++) ex_data[0][k] = '0;
        ex_vld[0] = '0;
        ex_err[0] = 1'b0;
        check_bank("arst", 0);
        repeat (12) tick();
        reset = 1'b0;
        base = iss_addr.size(); d0 = n_done; s0 = n_strobe;
        wait_issue(base + 2, "restart");
        run_a = 1'b0;
        repeat (40) tick();
        chk("stop_issue_count", 64'(iss_addr.size() - base), 64'(2));
        chk("restart_addr0", 64'(iss_addr[base]), 64'(16'h10));
        chk("stop_addr1", 64'(iss_addr[base+1]), 64'(16'h12));
        chk("stop_no_done", 64'(n_done - d0), 64'(0));
        chk("stop_strobes", 64'(n_strobe - s0), 64'(2));
        chk("stop_en_idle", 64'(en_a), 64'(0));
        for (int k = 0; k < 2; k++) begin
            ex_data[0][k] = 16'hA000 + slot_addr(k);
            ex_vld[0][k] = 1'b1;
        end
        check_bank("stop", 0);

        // Zero-period instance: timeout coinciding with busy fall, clear vs set
        sel = 1'b1;
        hold_cycles = 17;
        dev = device_addr;
        base = iss_addr.size(); d0 = n_done; s0 = n_strobe;
        run_b = 1'b1;
        wait_issue(base + 1, "b0");
        repeat (TMO - 1) tick();
        chk("b_err_before", 64'(te_b), 64'(0));
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("b_set_beats_clear", 64'(te_b), 64'(1));
        chk("b_coincide_no_strobe", 64'(n_strobe - s0), 64'(0));
        wait_done(d0 + 1, "b0");
        predict_sweep(1, 16'hFFFF, 17);
        check_sweep("b0", base, dev);
        check_bank("b0", 1);
        hold_cycles = 5;
        base = iss_addr.size(); d0 = n_done;
        wait_issue(base + 1, "b1");
        chk("b_gap0", 64'(last_gap), 64'(1));
        wait_done(d0 + 1, "b1");
        wait_issue(base + 5, "b2");
        chk("b_gap1", 64'(last_gap), 64'(1));
        wait_done(d0 + 2, "b2");
        run_b = 1'b0;
        predict_sweep(1, 16'hFFFF, 5);
        check_sweep("b2", base + 4, dev);
        check_bank("b2", 1);
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
